// File: rtl/btn_step_debounce_pkg.sv
// Shared definitions for the step-button conditioner: the 2-bit FSM state
// encoding, the board-clock default debounce length and a small helper.
package btn_step_debounce_pkg;

  // Debounce FSM states (2-bit encoding, reused by other IO blocks)
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_REL_WAIT   = 2'd3
  } btn_state_e;

  // 10 ms at the 100 MHz board clock
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd1000000;

  // Larger of two unsigned values, used to size shared counters
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/btn_step_debounce_if.sv
// Button pad and conditioned-button signals between the pad, the
// conditioner (slave) and its consumer, the PDU step input (master).
interface btn_step_debounce_if;
  logic       btn_raw;
  logic       btn_level;
  logic       btn_pulse;
  logic       btn_rel_pulse;
  logic [7:0] press_cnt;

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output btn_rel_pulse,
    output press_cnt
  );

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  btn_rel_pulse,
    input  press_cnt
  );
endinterface

// File: rtl/btn_step_debounce_sync_ff.sv
// sync_ff: N-stage synchroniser for a single asynchronous input, with
// synchronous active-high reset clearing every stage.
module sync_ff #(
  parameter int unsigned STAGES = 32'd2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/btn_step_debounce.sv
// btn_step_debounce: synchronises and debounces the single-step push button
// and produces a clean level plus one-cycle press and release strobes.
// Optional feature macro: BTN_AUTO_REPEAT_EN (auto-repeat press pulses
// while the button is held).
module btn_step_debounce
  import btn_step_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 32'd2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = 32'd50000000,
  parameter int unsigned REPEAT_CYCLES   = 32'd10000000
) (
  input  logic                clk,
  input  logic                rst,
  btn_step_debounce_if.slave  btn
);

  if (SYNC_STAGES < 32'd2 || DEBOUNCE_CYCLES < 32'd2 ||
      HOLD_CYCLES < 32'd1 || REPEAT_CYCLES < 32'd1) begin : g_param_check
    $error("btn_step_debounce: illegal parameter value");
  end

  // cnt is cleared on every state entry, so it never needs to exceed LAST
  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic             btn_sync_s;
  btn_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             level_r, level_s;
  logic             pulse_r, pulse_s;
  logic             rel_r, rel_s;
  logic [7:0]       press_cnt_r, press_cnt_s;

`ifdef BTN_AUTO_REPEAT_EN
  // One counter serves both the initial hold and the repeat period
  localparam int unsigned HOLD_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);

  logic [HOLD_W-1:0] hold_r, hold_s;
  logic              rep_r, rep_s;   // first repeat already issued
`endif

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn.btn_raw),
    .q   (btn_sync_s)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      level_r     <= 1'b0;
      pulse_r     <= 1'b0;
      rel_r       <= 1'b0;
      press_cnt_r <= 8'd0;
`ifdef BTN_AUTO_REPEAT_EN
      hold_r      <= {HOLD_W{1'b0}};
      rep_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      level_r     <= level_s;
      pulse_r     <= pulse_s;
      rel_r       <= rel_s;
      press_cnt_r <= press_cnt_s;
`ifdef BTN_AUTO_REPEAT_EN
      hold_r      <= hold_s;
      rep_r       <= rep_s;
`endif
    end
  end

  // Next-state logic: debounce in both directions, strobes last one cycle
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    level_s     = level_r;
    pulse_s     = 1'b0;
    rel_s       = 1'b0;
    press_cnt_s = press_cnt_r;
`ifdef BTN_AUTO_REPEAT_EN
    hold_s      = hold_r;
    rep_s       = rep_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (btn_sync_s) begin
          state_s = ST_PRESS_WAIT;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_sync_s) begin
          state_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_s     = ST_PRESSED;
          level_s     = 1'b1;
          pulse_s     = 1'b1;
          press_cnt_s = press_cnt_r + 8'd1;
`ifdef BTN_AUTO_REPEAT_EN
          hold_s      = {HOLD_W{1'b0}};
          rep_s       = 1'b0;
`endif
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!btn_sync_s) begin
          state_s = ST_REL_WAIT;
          cnt_s   = {CNT_W{1'b0}};
`ifdef BTN_AUTO_REPEAT_EN
          hold_s  = {HOLD_W{1'b0}};
          rep_s   = 1'b0;
`endif
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          if ((!rep_r && hold_r == HOLD_LAST) || (rep_r && hold_r == REP_LAST)) begin
            pulse_s     = 1'b1;
            press_cnt_s = press_cnt_r + 8'd1;
            hold_s      = {HOLD_W{1'b0}};
            rep_s       = 1'b1;
          end else begin
            hold_s = hold_r + HOLD_ONE;
          end
`else
          state_s = ST_PRESSED;
`endif
        end
      end
      ST_REL_WAIT: begin
        if (btn_sync_s) begin
          // Release bounce: back to pressed without a new strobe
          state_s = ST_PRESSED;
`ifdef BTN_AUTO_REPEAT_EN
          hold_s  = {HOLD_W{1'b0}};
          rep_s   = 1'b0;
`endif
        end else if (cnt_r == CNT_LAST) begin
          state_s = ST_IDLE;
          level_s = 1'b0;
          rel_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
        level_s = 1'b0;
      end
    endcase
  end

  assign btn.btn_level     = level_r;
  assign btn.btn_pulse     = pulse_r;
  assign btn.btn_rel_pulse = rel_r;
  assign btn.press_cnt     = press_cnt_r;

endmodule

// File: tb/tb_btn_step_debounce.sv
// Self-checking bench for btn_step_debounce: table-driven segments, a few
// hand-written corner sequences and randomized stimulus, all compared
// against a run-length reference model of the debounce rules.
module tb_btn_step_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int REP  = 3;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_step_debounce_if bif ();

  btn_step_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_pulse = 0;
  int n_rel = 0;

  // Reference model: accepted level flips once the synchronised input has
  // disagreed with it for DEB+1 consecutive samples; repeats are timed by the
  // number of consecutive stable pressed samples.
  logic       m_pipe [SYNC];
  logic       m_level;
  logic       m_pulse;
  logic       m_rel;
  int         m_run;
  int         m_hold;
  logic [7:0] m_cnt;

  function automatic void model_edge(input logic r, input logic raw);
    logic s;
    s = m_pipe[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = raw;
    m_pulse = 1'b0;
    m_rel   = 1'b0;
    if (r) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
      m_level = 1'b0;
      m_run   = 0;
      m_hold  = 0;
      m_cnt   = 8'd0;
    end else if (!m_level) begin
      if (s) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = 1'b1; m_pulse = 1'b1; m_cnt = m_cnt + 8'd1;
          m_run = 0; m_hold = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (!s) begin
        m_run++;
        m_hold = 0;
        if (m_run == DEB + 1) begin
          m_level = 1'b0; m_rel = 1'b1; m_run = 0;
        end
      end else if (m_run > 0) begin
        m_run = 0;
        m_hold = 0;
      end else begin
        m_hold++;
        if (AR && (m_hold == HOLD || (m_hold > HOLD && (m_hold - HOLD) % REP == 0))) begin
          m_pulse = 1'b1;
          m_cnt = m_cnt + 8'd1;
        end
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance model with the pre-edge inputs, then compare
  task automatic step();
    @(posedge clk);
    model_edge(rst, bif.btn_raw);
    #1;
    if (bif.btn_pulse) n_pulse++;
    if (bif.btn_rel_pulse) n_rel++;
    check("level", int'(bif.btn_level), int'(m_level));
    check("pulse", int'(bif.btn_pulse), int'(m_pulse));
    check("rel_pulse", int'(bif.btn_rel_pulse), int'(m_rel));
    check("press_cnt", int'(bif.press_cnt), int'(m_cnt));
    check("strobe_excl", int'(bif.btn_pulse & bif.btn_rel_pulse), 0);
  endtask

  typedef struct {
    logic raw;
    int   cycles;
    logic exp_level;
    int   exp_pulses;
    int   exp_rels;
    int   exp_cnt;
  } vec_t;

  vec_t vt [8];
  int   p0, r0, lat, first;
  int   offs [$];
  int   exp_offs [$];

  initial begin
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
    m_level = 1'b0; m_pulse = 1'b0; m_rel = 1'b0;
    m_run = 0; m_hold = 0; m_cnt = 8'd0;

    // clean press, release, glitch, release bounce
    vt[0] = '{1'b1, 12, 1'b1, 1, 0, 1};
    vt[1] = '{1'b0, 12, 1'b0, 0, 1, 1};
    vt[2] = '{1'b1,  3, 1'b0, 0, 0, 1};
    vt[3] = '{1'b0, 10, 1'b0, 0, 0, 1};
    vt[4] = '{1'b1, 10, 1'b1, 1, 0, 2};
    vt[5] = '{1'b0,  2, 1'b1, 0, 0, 2};
    vt[6] = '{1'b1,  1, 1'b1, 0, 0, 2};
    vt[7] = '{1'b0, 10, 1'b0, 0, 1, 2};

    bif.btn_raw = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("reset_level", int'(bif.btn_level), 0);
    check("reset_cnt", int'(bif.press_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      bif.btn_raw = vt[i].raw;
      p0 = n_pulse;
      r0 = n_rel;
      repeat (vt[i].cycles) step();
      check($sformatf("seg%0d_pulses", i), n_pulse - p0, vt[i].exp_pulses);
      check($sformatf("seg%0d_rels", i), n_rel - r0, vt[i].exp_rels);
      check($sformatf("seg%0d_level", i), int'(bif.btn_level), int'(vt[i].exp_level));
      check($sformatf("seg%0d_cnt", i), int'(bif.press_cnt), vt[i].exp_cnt);
    end

    // Reset during PRESS_WAIT with the button still held
    bif.btn_raw = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("rst_mid_level", int'(bif.btn_level), 0);
    check("rst_mid_pulse", int'(bif.btn_pulse), 0);
    check("rst_mid_cnt", int'(bif.press_cnt), 0);
    rst = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bif.btn_pulse && lat < 0) lat = k;
    end
    check("rst_latency", lat, SYNC + DEB);
    bif.btn_raw = 1'b0;
    repeat (12) step();

    // 256 clean presses wrap press_cnt back to 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    p0 = n_pulse;
    for (int k = 0; k < 256; k++) begin
      bif.btn_raw = 1'b1;
      repeat (8) step();
      bif.btn_raw = 1'b0;
      repeat (8) step();
    end
    check("wrap_pulses", n_pulse - p0, 256);
    check("wrap_cnt", int'(bif.press_cnt), 0);

    // Long hold: one pulse, or auto-repeat pulses at +0, +8, +11, ...
    rst = 1'b1;
    step();
    rst = 1'b0;
    bif.btn_raw = 1'b1;
    for (int k = 0; k < 42; k++) begin
      if (k == 30) bif.btn_raw = 1'b0;
      step();
      if (bif.btn_pulse) offs.push_back(k);
    end
    exp_offs.push_back(0);
    if (AR) begin
      exp_offs.push_back(8);  exp_offs.push_back(11); exp_offs.push_back(14);
      exp_offs.push_back(17); exp_offs.push_back(20); exp_offs.push_back(23);
    end
    check("hold_pulse_count", offs.size(), exp_offs.size());
    first = (offs.size() > 0) ? offs[0] : 0;
    for (int k = 0; k < exp_offs.size() && k < offs.size(); k++)
      check($sformatf("hold_offset%0d", k), offs[k] - first, exp_offs[k]);

    // Randomized runs of random length, occasional reset
    for (int k = 0; k < 300; k++) begin
      int len;
      bif.btn_raw = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        rst = ($urandom_range(0, 199) == 0);
        step();
      end
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
